// File: rtl/aemb2_mdu_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// master drives operands and strobes; slave returns busy, result, tag and flags.
interface aemb2_mdu_if #(
    parameter int DW = 32
);
    logic          ena_i;
    logic          stb_i;
    logic [1:0]    op_i;
    logic          tid_i;
    logic [DW-1:0] opa_i;
    logic [DW-1:0] opb_i;
    logic          busy_o;
    logic          vld_o;
    logic [DW-1:0] res_o;
    logic          tid_o;
    logic          dbz_o;

    modport master (
        output ena_i, stb_i, op_i, tid_i, opa_i, opb_i,
        input  busy_o, vld_o, res_o, tid_o, dbz_o
    );

    modport slave (
        input  ena_i, stb_i, op_i, tid_i, opa_i, opb_i,
        output busy_o, vld_o, res_o, tid_o, dbz_o
    );
endinterface

// File: rtl/aemb2_mdu.sv
// Multiply/divide unit: pipelined signed multiplier plus iterative
// radix-2 divider. Ports: clk_i, rst_i (sync, active high), bus (slave).
module aemb2_mdu #(
    parameter int DW   = 32,
    parameter int MUL  = 1,
    parameter int DIV  = 1,
    parameter int MSTG = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    aemb2_mdu_if.slave  bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} st_t;

    st_t st_q, st_d;

    logic acc, mul_acc, div_acc;

    assign acc     = bus.ena_i & bus.stb_i & ~bus.busy_o;
    assign mul_acc = acc & (MUL != 0) & ~bus.op_i[1];
    assign div_acc = acc & (DIV != 0) & bus.op_i[1];

    // ---------------- multiplier pipeline ----------------
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          mres;

    assign prod = $signed(bus.opa_i) * $signed(bus.opb_i);
    assign mres = bus.op_i[0] ? prod[2*DW-1:DW] : prod[DW-1:0];

    logic          mv_q [MSTG];
    logic [DW-1:0] mr_q [MSTG];
    logic          mt_q [MSTG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MSTG; i++) begin
                mv_q[i] <= 1'b0;
                mr_q[i] <= '0;
                mt_q[i] <= 1'b0;
            end
        end else if (bus.ena_i) begin
            mv_q[0] <= mul_acc;
            mr_q[0] <= mres;
            mt_q[0] <= bus.tid_i;
            for (int i = 1; i < MSTG; i++) begin
                mv_q[i] <= mv_q[i-1];
                mr_q[i] <= mr_q[i-1];
                mt_q[i] <= mt_q[i-1];
            end
        end
    end

    // ---------------- divider datapath ----------------
    // dvs/quo hold the raw operands after accept, then their magnitudes.
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d;
    logic          neg_q, neg_d;
    logic          dbz_q, dbz_d;
    logic          dtid_q, dtid_d;

    logic [DW:0]   sh;
    logic [DW:0]   diff;

    assign sh   = {rem_q, quo_q[DW-1]};
    assign diff = sh - {1'b0, dvs_q};

    always_comb begin
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        sgn_d  = sgn_q;
        neg_d  = neg_q;
        dbz_d  = dbz_q;
        dtid_d = dtid_q;
        unique case (st_q)
            IDLE: begin
                if (div_acc) begin
                    dvs_d  = bus.opa_i;
                    quo_d  = bus.opb_i;
                    sgn_d  = ~bus.op_i[0];
                    dtid_d = bus.tid_i;
                end
            end
            PREP: begin
                if (sgn_q & dvs_q[DW-1]) dvs_d = -dvs_q;
                if (sgn_q & quo_q[DW-1]) quo_d = -quo_q;
                neg_d = sgn_q & (dvs_q[DW-1] ^ quo_q[DW-1]);
                dbz_d = (dvs_q == '0);
                rem_d = '0;
                cnt_d = CW'(DW);
            end
            ITER: begin
                // Restoring step: keep the difference only if it did not borrow.
                if (!diff[DW]) begin
                    rem_d = diff[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = sh[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
            end
            FIX: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
            dbz_q  <= 1'b0;
            dtid_q <= 1'b0;
        end else if (bus.ena_i) begin
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            sgn_q  <= sgn_d;
            neg_q  <= neg_d;
            dbz_q  <= dbz_d;
            dtid_q <= dtid_d;
        end
    end

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) st_q <= IDLE;
        else if (bus.ena_i) st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: if (div_acc) st_d = PREP;
            PREP: st_d = ITER;
            ITER: if (cnt_q == CW'(1)) st_d = FIX;
            FIX:  st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // FIX presents the divide result directly; a multiply can never be
    // in the last pipe stage then, since none is accepted while busy.
    logic          fix;
    logic [DW-1:0] qfix;

    assign fix  = (st_q == FIX);
    assign qfix = neg_q ? -quo_q : quo_q;

    always_comb begin
        bus.busy_o = (st_q != IDLE);
        bus.vld_o  = mv_q[MSTG-1] | fix;
        bus.res_o  = mr_q[MSTG-1];
        bus.tid_o  = mt_q[MSTG-1];
        bus.dbz_o  = 1'b0;
        if (fix) begin
            bus.res_o = dbz_q ? '0 : qfix;
            bus.tid_o = dtid_q;
            bus.dbz_o = dbz_q;
        end
    end
endmodule

// File: tb/tb_aemb2_mdu.sv
// Scoreboard bench for aemb2_mdu (DW=32, MSTG=2): directed vectors,
// expected results queued at issue and checked by a monitor.
module tb_aemb2_mdu;
    localparam int DW = 32;
    localparam int MSTG = 2;
    localparam int DLAT = DW + 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aemb2_mdu_if #(.DW(DW)) bus ();

    aemb2_mdu #(
        .DW(DW), .MUL(1), .DIV(1), .MSTG(MSTG)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          tid;
        logic          dbz;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ecnt = 0;

    always @(posedge clk) if (bus.ena_i) ecnt++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.ena_i && bus.vld_o) begin
            if (q.size() == 0) begin
                chk("unexpected_vld", 64'(bus.res_o), 64'hDEAD_0000_0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", 64'(bus.res_o), 64'(e.res));
                chk("tid", 64'(bus.tid_o), 64'(e.tid));
                chk("dbz", 64'(bus.dbz_o), 64'(e.dbz));
                chk("latency", 64'(ecnt), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic tid,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic push, input logic [DW-1:0] r,
                         input logic z);
        exp_t e;
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.op_i  = op;
        bus.tid_i = tid;
        bus.opa_i = a;
        bus.opb_i = b;
        if (push) begin
            e.res = r;
            e.tid = tid;
            e.dbz = z;
            e.cyc = ecnt + (op[1] ? DLAT : MSTG);
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.stb_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || bus.busy_o) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int bc;
        int k;
        rst = 1'b1;
        bus.ena_i = 1'b1;
        bus.stb_i = 1'b0;
        bus.op_i  = 2'b00;
        bus.tid_i = 1'b0;
        bus.opa_i = '0;
        bus.opb_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_vld", 64'(bus.vld_o), 64'd0);
        chk("rst_res", 64'(bus.res_o), 64'd0);
        chk("rst_tid", 64'(bus.tid_o), 64'd0);
        chk("rst_dbz", 64'(bus.dbz_o), 64'd0);
        rst = 1'b0;

        issue(2'b00, 1'b0, 32'd7, -32'sd3, 1'b1, 32'hFFFF_FFEB, 1'b0);
        idle();
        drain();

        issue(2'b01, 1'b1, 32'h8000_0000, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
        drain();

        issue(2'b00, 1'b0, 32'd3, 32'd5, 1'b1, 32'd15, 1'b0);
        issue(2'b00, 1'b1, -32'sd2, 32'd6, 1'b1, 32'hFFFF_FFF4, 1'b0);
        issue(2'b00, 1'b0, 32'd100000, 32'd100000, 1'b1,
              32'h540B_E400, 1'b0);
        issue(2'b01, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1,
              32'h3FFF_FFFF, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mul_busy", 64'(bus.busy_o), 64'd0);
        end
        drain();

        issue(2'b10, 1'b1, 32'd7, -32'sd100, 1'b1, 32'hFFFF_FFF2, 1'b0);
        idle();
        bc = 1;
        while (bus.busy_o && bc < 60) begin
            @(negedge clk);
            bc++;
        end
        chk("div_busy_cycles", 64'(bc - 1), 64'(DLAT));
        drain();

        issue(2'b11, 1'b0, 32'd7, 32'd100, 1'b1, 32'd14, 1'b0);
        idle();
        drain();

        issue(2'b10, 1'b1, 32'd0, 32'd55, 1'b1, 32'd0, 1'b1);
        idle();
        drain();

        issue(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1,
              32'h8000_0000, 1'b0);
        idle();
        drain();

        issue(2'b11, 1'b1, 32'd10, 32'd1000, 1'b1, 32'd100, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        issue(2'b11, 1'b0, 32'd3, 32'd9, 1'b0, 32'd0, 1'b0);
        idle();
        drain();

        issue(2'b11, 1'b0, 32'd5, 32'd50, 1'b1, 32'd10, 1'b0);
        idle();
        k = 1;
        while (k < 60 && !(bus.ena_i && bus.vld_o)) begin
            @(negedge clk);
            k++;
            if (k == 10) bus.ena_i = 1'b0;
            if (k == 15) bus.ena_i = 1'b1;
        end
        chk("ena_stall_cycle", 64'(k), 64'd39);
        drain();

        issue(2'b00, 1'b1, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0);
        issue(2'b10, 1'b0, -32'sd9, 32'd81, 1'b1, 32'hFFFF_FFF7, 1'b0);
        idle();
        drain();

        issue(2'b10, 1'b1, 32'd3, 32'd99, 1'b0, 32'd0, 1'b0);
        idle();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_busy", 64'(bus.busy_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("rst_abort_queue", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
